// File: rtl/midi_voice_allocator_if.sv
// Event handshake between the MIDI parser (master) and the voice allocator (slave).
interface midi_voice_allocator_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [6:0] ev_note;
    logic [6:0] ev_vel;

    modport master (output ev_valid, ev_on, ev_note, ev_vel, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_note, ev_vel, output ev_ready);
endinterface

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto VOICES note-clock
// generators with retrigger / free / steal-oldest selection and a load strobe.
module midi_voice_allocator #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 8
) (
    input  logic                  CLK24M,
    input  logic                  nRST,
    midi_voice_allocator_if.slave ev,
    output logic [7*VOICES-1:0]   voice_note,
    output logic [VOICES-1:0]     voice_active,
    output logic [VOICES-1:0]     voice_load
);

    localparam int IDX_W = $clog2(VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, STROBE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             cap_on;
    logic [6:0]       cap_note;

    logic             match_found;
    logic             free_found;
    logic             old_found;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] target;

    logic [6:0]       note_r [VOICES];
    logic [AGE_W-1:0] age_r  [VOICES];

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    assign ev.ev_ready = (state == IDLE);

    for (genvar g = 0; g < VOICES; g++) begin : g_note
        assign voice_note[7*g +: 7] = note_r[g];
    end

    // Retrigger beats a free voice, which beats stealing the oldest.
    always_comb begin
        sel_idx = old_idx;
        if (free_found)  sel_idx = free_idx;
        if (match_found) sel_idx = match_idx;
    end

    always_ff @(posedge CLK24M or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            idx          <= '0;
            cap_on       <= 1'b0;
            cap_note     <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            old_found    <= 1'b0;
            match_idx    <= '0;
            free_idx     <= '0;
            old_idx      <= '0;
            old_age      <= '0;
            target       <= '0;
            voice_active <= '0;
            voice_load   <= '0;
            for (int i = 0; i < VOICES; i++) begin
                note_r[i] <= '0;
                age_r[i]  <= '0;
            end
        end else begin
            voice_load <= '0;
            case (state)
                IDLE: begin
                    if (ev.ev_valid) begin
                        // Velocity-0 note-on is folded into note-off at capture.
                        cap_on      <= ev.ev_on && (ev.ev_vel != 7'd0);
                        cap_note    <= ev.ev_note;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        old_age     <= '0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (voice_active[idx]) begin
                        if (!match_found && note_r[idx] == cap_note) begin
                            match_found <= 1'b1;
                            match_idx   <= idx;
                        end
                        // Strict compare keeps the lowest index on age ties.
                        if (!old_found || age_r[idx] > old_age) begin
                            old_found <= 1'b1;
                            old_idx   <= idx;
                            old_age   <= age_r[idx];
                        end
                    end else if (!free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (idx == IDX_W'(VOICES-1)) state <= RESOLVE;
                    else                         idx   <= idx + 1'b1;
                end
                RESOLVE: begin
                    if (cap_on) begin
                        for (int i = 0; i < VOICES; i++) begin
                            if (IDX_W'(i) == sel_idx) begin
                                note_r[i]       <= cap_note;
                                voice_active[i] <= 1'b1;
                                age_r[i]        <= '0;
                            end else if (voice_active[i]) begin
                                age_r[i] <= sat_inc(age_r[i]);
                            end
                        end
                        target <= sel_idx;
                        state  <= STROBE;
                    end else begin
                        if (match_found) voice_active[match_idx] <= 1'b0;
                        state <= IDLE;
                    end
                end
                STROBE: begin
                    // Note was written one cycle earlier, so it is stable at this edge.
                    voice_load <= VOICES'(1) << target;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator (VOICES=4, AGE_W=8) with a load-strobe scoreboard.
module tb_midi_voice_allocator;

    localparam int VOICES = 4;

    logic                clk = 1'b0;
    logic                nrst = 1'b0;
    logic [7*VOICES-1:0] voice_note;
    logic [VOICES-1:0]   voice_active;
    logic [VOICES-1:0]   voice_load;

    int n_pass  = 0;
    int n_total = 0;

    logic [VOICES-1:0] exp_load_q [$];
    logic [6:0]        exp_note_q [$];

    midi_voice_allocator_if evif ();

    midi_voice_allocator #(.VOICES(VOICES), .AGE_W(8)) dut (
        .CLK24M       (clk),
        .nRST         (nrst),
        .ev           (evif),
        .voice_note   (voice_note),
        .voice_active (voice_active),
        .voice_load   (voice_load)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] note_of(input int v);
        return voice_note[7*v +: 7];
    endfunction

    // Scoreboard: each observed strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nrst && voice_load != '0) begin
            if (exp_load_q.size() == 0) begin
                check("load_unexpected", 32'(voice_load), 32'd0);
            end else begin
                logic [VOICES-1:0] el;
                logic [6:0]        en;
                int                v;
                el = exp_load_q.pop_front();
                en = exp_note_q.pop_front();
                v  = 0;
                for (int i = 0; i < VOICES; i++) if (voice_load[i]) v = i;
                check("load_vector", 32'(voice_load), 32'(el));
                check("load_note", 32'(note_of(v)), 32'(en));
            end
        end
    end

    // Drives one event and returns 1 time unit after its accept edge.
    task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel,
                        input logic [VOICES-1:0] exp_load);
        int t;
        t = 0;
        @(negedge clk);
        while (!evif.ev_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!evif.ev_ready) check("ready_timeout", 32'd0, 32'd1);
        evif.ev_valid = 1'b1;
        evif.ev_on    = on;
        evif.ev_note  = note;
        evif.ev_vel   = vel;
        if (exp_load != '0) begin
            exp_load_q.push_back(exp_load);
            exp_note_q.push_back(note);
        end
        @(posedge clk);
        #1;
        evif.ev_valid = 1'b0;
        evif.ev_on    = 1'($urandom);
        evif.ev_note  = 7'($urandom);
        evif.ev_vel   = 7'($urandom);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        evif.ev_valid = 1'b0;
        evif.ev_on    = 1'b0;
        evif.ev_note  = '0;
        evif.ev_vel   = '0;

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_note", 32'(voice_note), 32'd0);
        check("rst_active", 32'(voice_active), 32'd0);
        check("rst_load", 32'(voice_load), 32'd0);
        check("rst_ready", 32'(evif.ev_ready), 32'd1);
        @(negedge clk);
        nrst = 1'b1;

        // 2. first note-on with cycle-accurate timing
        send(1'b1, 7'd60, 7'd100, 4'b0001);
        repeat (5) @(posedge clk);
        #1;
        check("on1_e5_note0", 32'(note_of(0)), 32'd60);
        check("on1_e5_active", 32'(voice_active), 32'b0001);
        check("on1_e5_load", 32'(voice_load), 32'd0);
        check("on1_e5_ready", 32'(evif.ev_ready), 32'd0);
        @(posedge clk);
        #1;
        check("on1_e6_load", 32'(voice_load), 32'b0001);
        check("on1_e6_ready", 32'(evif.ev_ready), 32'd1);
        @(posedge clk);
        #1;
        check("on1_e7_load", 32'(voice_load), 32'd0);

        // 3. fill the remaining voices, then steal the oldest
        send(1'b1, 7'd62, 7'd90, 4'b0010);
        settle();
        send(1'b1, 7'd64, 7'd80, 4'b0100);
        settle();
        send(1'b1, 7'd65, 7'd70, 4'b1000);
        settle();
        check("fill_active", 32'(voice_active), 32'b1111);
        send(1'b1, 7'd67, 7'd60, 4'b0001);
        settle();
        check("steal_note0", 32'(note_of(0)), 32'd67);
        check("steal_note1", 32'(note_of(1)), 32'd62);
        check("steal_note2", 32'(note_of(2)), 32'd64);
        check("steal_note3", 32'(note_of(3)), 32'd65);
        check("steal_active", 32'(voice_active), 32'b1111);

        // 4. note-off frees voice 1, which then beats stealing
        send(1'b0, 7'd62, 7'd0, 4'b0000);
        repeat (4) @(posedge clk);
        #1;
        check("off_e4_ready", 32'(evif.ev_ready), 32'd0);
        @(posedge clk);
        #1;
        check("off_e5_active", 32'(voice_active), 32'b1101);
        check("off_e5_ready", 32'(evif.ev_ready), 32'd1);
        check("off_note_kept", 32'(note_of(1)), 32'd62);
        settle();
        send(1'b1, 7'd69, 7'd50, 4'b0010);
        settle();
        check("free_note1", 32'(note_of(1)), 32'd69);
        check("free_active", 32'(voice_active), 32'b1111);

        // 5. velocity-0 off, unknown off, retrigger
        send(1'b1, 7'd64, 7'd0, 4'b0000);
        settle();
        check("vel0_active", 32'(voice_active), 32'b1011);
        check("vel0_note2", 32'(note_of(2)), 32'd64);
        send(1'b0, 7'd100, 7'd0, 4'b0000);
        settle();
        check("unk_active", 32'(voice_active), 32'b1011);
        check("unk_notes", 32'(voice_note), {4'd0, 7'd65, 7'd64, 7'd69, 7'd67});
        send(1'b1, 7'd65, 7'd40, 4'b1000);
        settle();
        check("retrig_active", 32'(voice_active), 32'b1011);
        check("retrig_notes", 32'(voice_note), {4'd0, 7'd65, 7'd64, 7'd69, 7'd67});

        // 6. reset in the middle of a scan
        send(1'b1, 7'd70, 7'd30, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check("mid_rst_note", 32'(voice_note), 32'd0);
        check("mid_rst_active", 32'(voice_active), 32'd0);
        check("mid_rst_load", 32'(voice_load), 32'd0);
        check("mid_rst_ready", 32'(evif.ev_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("post_rst_ready", 32'(evif.ev_ready), 32'd1);
        send(1'b1, 7'd71, 7'd100, 4'b0001);
        settle();
        check("post_rst_note0", 32'(note_of(0)), 32'd71);
        check("post_rst_active", 32'(voice_active), 32'b0001);

        check("sb_drained", 32'(exp_load_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
